// File: rtl/stream_mac_pipe_if.sv
// Stream handshake bundle for the multiply-accumulate pipe: operand beats in,
// product/sum beats out. The block connects through the slave modport.
interface stream_mac_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_payload_a;
    logic [DATA_W-1:0] i_payload_b;
    logic              i_signed;
    logic              i_accum;
    logic              i_last;
    logic              o_valid;
    logic              o_ready;
    logic [ACC_W-1:0]  o_payload;
    logic              o_overflow;

    modport master (
        output i_valid, i_payload_a, i_payload_b, i_signed, i_accum, i_last, o_ready,
        input  i_ready, o_valid, o_payload, o_overflow
    );

    modport slave (
        input  i_valid, i_payload_a, i_payload_b, i_signed, i_accum, i_last, o_ready,
        output i_ready, o_valid, o_payload, o_overflow
    );
endinterface

// File: rtl/stream_mac_pipe.sv
// Elastic multiply/accumulate pipeline: product formed on acceptance, carried
// through STAGES valid-tagged registers, then summed or emitted at the tail.
module stream_mac_pipe #(
    parameter int DATA_W = 16,
    parameter int STAGES = 3,
    parameter int ACC_W  = 40
) (
    input logic              clk,
    input logic              reset,
    stream_mac_pipe_if.slave bus
);

    function automatic logic [ACC_W-1:0] ext_product(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic              sgn);
        logic signed [2*DATA_W-1:0] sa, sb, sp;
        logic        [2*DATA_W-1:0] ua, ub, up;
        sa = (2*DATA_W)'($signed(a));
        sb = (2*DATA_W)'($signed(b));
        sp = sa * sb;
        ua = (2*DATA_W)'(a);
        ub = (2*DATA_W)'(b);
        up = ua * ub;
        return sgn ? ACC_W'(sp) : ACC_W'(up);
    endfunction

    // Returns {overflow, wrapped sum}; overflow is carry-out or signed overflow per sgn.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] p,
                                               input logic             sgn);
        logic [ACC_W:0] wide;
        logic           ovf;
        wide = {1'b0, acc} + {1'b0, p};
        if (sgn) ovf = (acc[ACC_W-1] == p[ACC_W-1]) && (wide[ACC_W-1] != acc[ACC_W-1]);
        else     ovf = wide[ACC_W];
        return {ovf, wide[ACC_W-1:0]};
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [ACC_W-1:0]  prod_p [STAGES];
    logic [STAGES-1:0] sgn_p;
    logic [STAGES-1:0] accum_p;
    logic [STAGES-1:0] last_p;
    logic [STAGES-1:0] adv;

    logic [ACC_W-1:0]  acc;
    logic              acc_ovf;
    logic [ACC_W:0]    sum;
    logic              out_free;
    logic              fin_sink;
    logic              fin_go;
    logic              fin_emit;
    logic              in_fire;

    assign out_free = !bus.o_valid || bus.o_ready;
    // Non-final accumulate beats are consumed by the accumulator, so they never wait on the output.
    assign fin_sink = accum_p[STAGES-1] && !last_p[STAGES-1];
    assign fin_go   = vld_p[STAGES-1] && (fin_sink || out_free);
    assign fin_emit = fin_go && !fin_sink;
    assign sum      = acc_add(acc, prod_p[STAGES-1], sgn_p[STAGES-1]);

    assign bus.i_ready = !reset && (!vld_p[0] || adv[0]);
    assign in_fire     = bus.i_valid && bus.i_ready;

    // A stage moves if any later stage is empty or the tail itself drains.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = vld_p[k] && (hole || fin_go);
            hole   = hole || !vld_p[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_fire || (vld_p[0] && !adv[0]);
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= adv[k-1] || (vld_p[k] && !adv[k]);
            end
        end
    end

    // Stage 0 captures the extended product; later stages shift on advance.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            prod_p[0]  <= ext_product(bus.i_payload_a, bus.i_payload_b, bus.i_signed);
            sgn_p[0]   <= bus.i_signed;
            accum_p[0] <= bus.i_accum;
            last_p[0]  <= bus.i_last;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                prod_p[k]  <= prod_p[k-1];
                sgn_p[k]   <= sgn_p[k-1];
                accum_p[k] <= accum_p[k-1];
                last_p[k]  <= last_p[k-1];
            end
        end
    end

    // Output register and accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_valid    <= 1'b0;
            bus.o_payload  <= '0;
            bus.o_overflow <= 1'b0;
            acc            <= '0;
            acc_ovf        <= 1'b0;
        end else begin
            if (fin_emit) begin
                bus.o_valid <= 1'b1;
                if (accum_p[STAGES-1]) begin
                    bus.o_payload  <= sum[ACC_W-1:0];
                    bus.o_overflow <= acc_ovf || sum[ACC_W];
                    acc            <= '0;
                    acc_ovf        <= 1'b0;
                end else begin
                    bus.o_payload  <= prod_p[STAGES-1];
                    bus.o_overflow <= 1'b0;
                end
            end else if (bus.o_ready) begin
                bus.o_valid <= 1'b0;
            end
            if (fin_go && fin_sink) begin
                acc     <= sum[ACC_W-1:0];
                acc_ovf <= acc_ovf || sum[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_stream_mac_pipe.sv
// Directed bench for stream_mac_pipe: queue-based reference model with a
// per-cycle compare process, plus literal expectations for key vectors.
module tb_stream_mac_pipe;
    localparam int DW   = 16;
    localparam int ST   = 3;
    localparam int AW   = 40;
    localparam int AW32 = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stream_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW))   bus();
    stream_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW32)) bus32();

    stream_mac_pipe #(.DATA_W(DW), .STAGES(ST), .ACC_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    stream_mac_pipe #(.DATA_W(DW), .STAGES(ST), .ACC_W(AW32)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: results are pushed in acceptance order, groups summed with wide integers.
    typedef struct packed {
        logic [AW-1:0] pay;
        logic          ovf;
    } exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] m_acc = '0;
    logic          m_ovf = 1'b0;

    function automatic longint beat_product(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic sgn);
        if (sgn) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic sgn, input logic accm, input logic last);
        longint        p;
        longint        s;
        logic [63:0]   bits;
        logic [AW-1:0] pe;
        logic          o;
        p    = beat_product(a, b, sgn);
        bits = p;
        pe   = bits[AW-1:0];
        if (!accm) begin
            exp_q.push_back('{pay: pe, ovf: 1'b0});
        end else begin
            if (sgn) begin
                s = longint'($signed(m_acc)) + p;
                o = (s > ((longint'(1) <<< (AW-1)) - 1)) || (s < -(longint'(1) <<< (AW-1)));
            end else begin
                s = longint'(m_acc) + longint'(pe);
                o = s >= (longint'(1) <<< AW);
            end
            bits  = s;
            m_acc = bits[AW-1:0];
            m_ovf = m_ovf | o;
            if (last) begin
                exp_q.push_back('{pay: m_acc, ovf: m_ovf});
                m_acc = '0;
                m_ovf = 1'b0;
            end
        end
    endtask

    logic          held = 1'b0;
    logic [AW-1:0] held_pay;
    logic          held_ovf;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_acc = '0;
            m_ovf = 1'b0;
            held  = 1'b0;
        end else begin
            if (held) begin
                check("stall_hold_valid", 64'(bus.o_valid), 64'd1);
                check("stall_hold_payload", 64'(bus.o_payload), 64'(held_pay));
                check("stall_hold_overflow", 64'(bus.o_overflow), 64'(held_ovf));
            end
            held     = bus.o_valid && !bus.o_ready;
            held_pay = bus.o_payload;
            held_ovf = bus.o_overflow;
            if (bus.o_valid && bus.o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=0x%0h required=no_beat", bus.o_payload);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("model_payload", 64'(bus.o_payload), 64'(e.pay));
                    check("model_overflow", 64'(bus.o_overflow), 64'(e.ovf));
                end
            end
            if (bus.i_valid && bus.i_ready)
                model_accept(bus.i_payload_a, bus.i_payload_b, bus.i_signed, bus.i_accum, bus.i_last);
        end
    end

    task automatic set_in(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sgn, input logic accm, input logic last);
        bus.i_valid     = 1'b1;
        bus.i_payload_a = a;
        bus.i_payload_b = b;
        bus.i_signed    = sgn;
        bus.i_accum     = accm;
        bus.i_last      = last;
    endtask

    // All driving tasks start and end at posedge+1.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sgn, input logic accm, input logic last);
        logic hs;
        logic done;
        done = 1'b0;
        set_in(a, b, sgn, accm, last);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = bus.i_ready;
            @(posedge clk);
            #1;
            done = hs;
        end
        bus.i_valid = 1'b0;
        if (!done) fail_now("send_accept");
    endtask

    task automatic wait_out(input string name, input logic [63:0] pay, input logic ovf);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.o_valid && bus.o_ready) begin
                check({name, "_payload"}, 64'(bus.o_payload), pay);
                check({name, "_overflow"}, 64'(bus.o_overflow), 64'(ovf));
                got = 1'b1;
            end
        end
        if (!got) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sgn, input logic accm, input logic last);
        bus32.i_valid     = 1'b1;
        bus32.i_payload_a = a;
        bus32.i_payload_b = b;
        bus32.i_signed    = sgn;
        bus32.i_accum     = accm;
        bus32.i_last      = last;
        @(negedge clk);
        check("ready32", 64'(bus32.i_ready), 64'd1);
        @(posedge clk);
        #1;
        bus32.i_valid = 1'b0;
    endtask

    task automatic wait32(input string name, input logic [63:0] pay, input logic ovf);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus32.o_valid) begin
                check({name, "_payload"}, 64'(bus32.o_payload), pay);
                check({name, "_overflow"}, 64'(bus32.o_overflow), 64'(ovf));
                got = 1'b1;
            end
        end
        if (!got) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  vpat;
        logic [63:0] pay;
        logic [63:0] first_pay;
        logic [63:0] last_pay;
        int          n;
        int          acc_n;
        int          outs;

        bus.i_valid = 1'b0; bus.i_payload_a = '0; bus.i_payload_b = '0;
        bus.i_signed = 1'b0; bus.i_accum = 1'b0; bus.i_last = 1'b0; bus.o_ready = 1'b1;
        bus32.i_valid = 1'b0; bus32.i_payload_a = '0; bus32.i_payload_b = '0;
        bus32.i_signed = 1'b0; bus32.i_accum = 1'b0; bus32.i_last = 1'b0; bus32.o_ready = 1'b1;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_i_ready", 64'(bus.i_ready), 64'd0);
        check("reset_o_valid", 64'(bus.o_valid), 64'd0);
        check("reset_o_payload", 64'(bus.o_payload), 64'd0);
        check("reset_o_overflow", 64'(bus.o_overflow), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.i_ready), 64'd1);
        @(posedge clk);
        #1;

        // Unsigned 3x4: valid exactly in the 4th half-cycle window after acceptance
        send(16'd3, 16'd4, 1'b0, 1'b0, 1'b0);
        pay = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vpat[i] = bus.o_valid;
            if (i == 3) pay = 64'(bus.o_payload);
        end
        check("latency_valid_pattern", 64'(vpat), 64'b01000);
        check("latency_payload", pay, 64'd12);
        @(posedge clk);
        #1;

        send(16'hFFFE, 16'd3, 1'b1, 1'b0, 1'b0);
        wait_out("signed_product", 64'hFF_FFFF_FFFA, 1'b0);
        send(16'hFFFE, 16'd3, 1'b0, 1'b0, 1'b0);
        wait_out("unsigned_product", 64'h2_FFFA, 1'b0);

        send(16'd2, 16'd3, 1'b0, 1'b1, 1'b0);
        send(16'd4, 16'd5, 1'b0, 1'b1, 1'b0);
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b1);
        n = 0;
        pay = '0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_valid) begin
                n++;
                pay = 64'(bus.o_payload);
            end
        end
        check("group_beat_count", 64'(n), 64'd1);
        check("group_sum", pay, 64'd27);
        @(posedge clk);
        #1;

        send(16'd10, 16'd10, 1'b0, 1'b1, 1'b0);
        send(16'd5, 16'd6, 1'b0, 1'b0, 1'b0);
        wait_out("plain_mid_group", 64'd30, 1'b0);
        send(16'hFFFF, 16'd1, 1'b1, 1'b1, 1'b1);
        wait_out("mixed_sign_group", 64'd99, 1'b0);

        // Backpressure: ten stalled cycles with continuous offers
        bus.o_ready = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 10; c++) begin
            set_in(16'(acc_n + 1), 16'd1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.i_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(acc_n), 64'(ST + 1));
        check("bp_ready_low", 64'(bus.i_ready), 64'd0);
        bus.o_ready = 1'b1;
        outs = 0;
        first_pay = '0;
        last_pay = '0;
        for (int c = 0; c < 40; c++) begin
            if (acc_n < 8) set_in(16'(acc_n + 1), 16'd1, 1'b0, 1'b0, 1'b0);
            else bus.i_valid = 1'b0;
            @(negedge clk);
            if (bus.i_valid && bus.i_ready) acc_n++;
            if (bus.o_valid && bus.o_ready) begin
                outs++;
                if (outs == 1) first_pay = 64'(bus.o_payload);
                last_pay = 64'(bus.o_payload);
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        check("bp_output_count", 64'(outs), 64'd8);
        check("bp_first_payload", first_pay, 64'd1);
        check("bp_last_payload", last_pay, 64'd8);

        // Accumulate beats drain past a full output register
        bus.o_ready = 1'b0;
        send(16'd2, 16'd2, 1'b0, 1'b0, 1'b0);
        send(16'd3, 16'd3, 1'b0, 1'b1, 1'b0);
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b1);
        cycles(6);
        check("full_out_payload", 64'(bus.o_payload), 64'd4);
        check("full_out_ready", 64'(bus.i_ready), 64'd1);
        bus.o_ready = 1'b1;
        wait_out("plain_before_group", 64'd4, 1'b0);
        wait_out("group_after_stall", 64'd10, 1'b0);

        // Reset during a stall with a group open
        bus.o_ready = 1'b0;
        send(16'd9, 16'd9, 1'b0, 1'b0, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        send(16'd3, 16'd3, 1'b0, 1'b1, 1'b0);
        cycles(4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_stall_o_valid", 64'(bus.o_valid), 64'd0);
        check("reset_stall_o_payload", 64'(bus.o_payload), 64'd0);
        reset = 1'b0;
        bus.o_ready = 1'b1;
        send(16'd1, 16'd7, 1'b0, 1'b1, 1'b1);
        wait_out("group_after_reset", 64'd7, 1'b0);

        send32(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        send32(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        wait32("wrap32", 64'hFFFC_0002, 1'b1);
        send32(16'd1, 16'd1, 1'b0, 1'b1, 1'b1);
        wait32("fresh_group32", 64'd1, 1'b0);
        send32(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
        send32(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
        wait32("signed_ovf32", 64'h8000_0000, 1'b1);

        cycles(4);
        check("model_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_mac_pipe.md
STREAM_MAC_PIPE -- requirements
Module: stream_mac_pipe

Interface
REQ-001 Parameter DATA_W, default 16: width of each input operand.
REQ-002 Parameter STAGES, default 3, legal 1..8: number of pipeline register stages from input acceptance to output register.
REQ-003 Parameter ACC_W, default 40, legal >= 2*DATA_W: accumulator and output payload width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 i_ready  output  1  block can accept an input beat this cycle.
REQ-008 i_payload_a  input  DATA_W  operand A.
REQ-009 i_payload_b  input  DATA_W  operand B.
REQ-010 i_signed  input  1  per-beat: 1 = two's-complement operands, 0 = unsigned.
REQ-011 i_accum  input  1  per-beat: 0 = plain multiply, 1 = accumulate into running sum.
REQ-012 i_last  input  1  per-beat, meaningful only when i_accum=1: closes the accumulation group.
REQ-013 o_valid  output  1  output beat valid.
REQ-014 o_ready  input  1  downstream can accept an output beat.
REQ-015 o_payload  output  ACC_W  result: product or accumulated sum, sign- or zero-extended to ACC_W.
REQ-016 o_overflow  output  1  qualifies o_payload: set if the accumulation group wrapped ACC_W.

Function
REQ-017 Input transfer SHALL occur when i_valid && i_ready; output transfer SHALL occur when o_valid && o_ready.
REQ-018 Pipeline SHALL hold STAGES stages, each with a valid bit; a stage SHALL advance when its successor is empty or advancing in the same cycle.
REQ-019 i_ready SHALL equal (stage 1 empty) OR (stage 1 advancing); it SHALL not depend combinationally on i_valid.
REQ-020 With o_ready held high, a plain beat accepted at edge N SHALL present o_valid=1 with its result after edge N+STAGES; throughput one beat per cycle.
REQ-021 o_valid=1 with o_ready=0 SHALL hold o_payload and o_overflow stable and SHALL stall all upstream stages whose successor is full; no beat is dropped or duplicated.
REQ-022 Product SHALL be full-precision 2*DATA_W bits, signed or unsigned per the beat's i_signed, then extended to ACC_W matching that signedness.
REQ-023 Accumulate beats (i_accum=1, i_last=0) SHALL add their extended product into an internal accumulator when they leave the final stage and SHALL produce no output beat.
REQ-024 An accumulate beat with i_last=1 SHALL emit accumulator + its product as one output beat, then clear the accumulator and overflow flag to zero in the same cycle.
REQ-025 Accumulator addition SHALL wrap modulo 2^ACC_W; o_overflow SHALL be set on the group's final output if any addition in the group overflowed (signed overflow when i_signed=1, carry-out when 0).
REQ-026 A plain beat arriving while an accumulation group is open SHALL output its own product and SHALL leave the accumulator unchanged.
REQ-027 Accumulate beats SHALL update the accumulator even while the output register is full, provided the final stage is not stalled; a final (i_last) beat SHALL wait in the final stage until the output register is free.
REQ-028 o_overflow SHALL be 0 for plain beats.
REQ-029 Mixing i_signed values within one group SHALL be permitted; each product is extended by its own beat's flag.

Reset
REQ-030 On reset, all stage valid bits, o_valid, o_payload, o_overflow, accumulator and overflow flag SHALL be 0; in-flight beats and open groups are discarded.
REQ-031 i_ready SHALL be 0 during the reset cycle and SHALL be 1 in the first cycle after reset is released.
REQ-032 Reset asserted during a stall or mid-group SHALL take priority over every transfer in that cycle.

Verification
REQ-033 STAGES=3, o_ready=1, unsigned 3x4 at cycle 0 -> o_valid=1, o_payload=12 after edge 3, one cycle only.
REQ-034 Signed -2 x 3 (DATA_W=16) -> o_payload = -6 sign-extended to 40 bits (0xFF_FFFF_FFFA), o_overflow=0; the same bit patterns with unsigned -> 0xFFFE*3 = 0x2_FFFA.
REQ-035 Group 2x3, 4x5, 1x1(last) back-to-back -> single output 27, exactly one o_valid beat.
REQ-036 o_ready=0 for 10 cycles with continuous i_valid -> i_ready drops after STAGES+1 accepted beats; on release all beats appear in order, none lost.
REQ-037 ACC_W=32, unsigned group 0xFFFFx0xFFFF, then 0xFFFFx0xFFFF(last) -> o_payload=0xFFFC_0002, o_overflow=1; next group starts from 0.
REQ-038 Reset mid-group after two accumulate beats, then group 1x7(last) -> output 7, o_overflow=0.
